// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter for the UART TX FIFO write port
//
// Purpose:
//   Shares the single TX FIFO write port among NUM_REQ byte-stream requesters.
//   A grant is held until the owner writes a byte marked last, or until
//   MAX_BURST bytes have been written (forced release, burst_abort pulse).
//   The next owner is chosen round-robin, starting after the previous owner.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i in bits [8i+7:8i]
//   req_last     per-requester end-of-packet marker
//   req_ready    per-requester accept (byte taken when valid & ready)
//   tx_data      byte to TX FIFO
//   tx_write     TX FIFO write strobe
//   tx_full      TX FIFO full
//   grant        one-hot current owner (registered)
//   busy         high while a grant is held
//   burst_abort  one-cycle pulse after a forced release at MAX_BURST

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_write,
  input  logic                   tx_full,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   burst_abort
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  // Pointer starts at the top requester so requester 0 wins first.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 burst_abort_q, burst_abort_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;
  logic [CNT_W-1:0]     count_inc;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    int               cand_i;
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_i     = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = (32'(last_owner_q) + k) % NUM_REQ;
      cand   = IDX_W'(cand_i);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Owner's stream selected through the one-hot grant (AND-OR mux).
  always_comb begin
    own_valid = |(req_valid & grant_q);
    own_last  = |(req_last & grant_q);
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_data |= req_data[8*i +: 8] & {8{grant_q[i]}};
    end
  end

  assign count_inc = count_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= PTR_RST;
      count_q       <= '0;
      burst_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      count_q       <= count_d;
      burst_abort_q <= burst_abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    count_d       = count_q;
    burst_abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          count_d = '0;
        end
      end
      XFER: begin
        if (tx_write) begin
          // A last byte wins over the burst limit on the same transfer.
          if (own_last) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            count_d      = '0;
          end else if (count_inc == CNT_MAX) begin
            state_d       = IDLE;
            grant_d       = '0;
            last_owner_d  = owner_q;
            count_d       = '0;
            burst_abort_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; strobes are forced low while reset is high.
  always_comb begin
    tx_write  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == XFER && !reset) begin
      req_ready = tx_full ? '0 : grant_q;
      tx_data   = own_data;
      tx_write  = own_valid & ~tx_full;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == XFER);
  assign burst_abort = burst_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_write;
  logic             tx_full = 1'b0;
  logic [N-1:0]     grant;
  logic             busy;
  logic             burst_abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .grant(grant), .busy(busy), .burst_abort(burst_abort)
  );

  // Source model: per-requester queue of {last, data}.
  logic [8:0]   src_q [N][$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] pop = '0;
  logic         rst_cmd = 1'b1;
  int           full_cnt = 0;
  int           cyc = 0;
  int           err_cnt = 0;
  int           chk_cnt = 0;
  int           abort_cnt = 0;
  int           abort_cyc = 0;
  int unsigned  wr_data [$];
  int unsigned  wr_owner [$];
  int unsigned  wr_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    reset = rst_cmd;
    for (int i = 0; i < N; i++) begin
      if (pop[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    pop = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_full = (full_cnt > 0);
    if (full_cnt > 0) full_cnt--;
  endtask

  task automatic sample();
    cyc++;
    pop = req_valid & req_ready;
    if (tx_write) begin
      wr_data.push_back(tx_data);
      wr_owner.push_back(onehot_idx(grant));
      wr_cyc.push_back(cyc);
    end
    if (burst_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_owner.delete();
    wr_cyc.delete();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((pending() || busy) && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, {31'b0, (pending() || busy)}, 0);
  endtask

  task automatic wait_writes(input string tag, input int cnt, input int max_cyc);
    int n;
    n = 0;
    while (wr_data.size() < cnt && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_wait_timeout"}, {31'b0, (wr_data.size() < cnt)}, 0);
  endtask

  task automatic check_log(input string tag, input int unsigned ed[$], input int unsigned eo[$]);
    check({tag, "_count"}, wr_data.size(), ed.size());
    for (int k = 0; k < ed.size(); k++) begin
      if (k < wr_data.size()) begin
        check($sformatf("%s_data%0d", tag, k), wr_data[k], ed[k]);
        check($sformatf("%s_owner%0d", tag, k), wr_owner[k], eo[k]);
      end
    end
  endtask

  initial begin
    int unsigned ed[$];
    int unsigned eo[$];
    int          exp_off[8];
    int          cyc0;

    // ---------------- reset state ----------------
    rst_cmd = 1'b1;
    repeat (3) step();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", burst_abort, 0);
    check("rst_tx_write", tx_write, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ready", req_ready, 0);
    rst_cmd = 1'b0;
    step();

    // ---------------- round-robin order 0,1,2,3 ----------------
    for (int i = 0; i < N; i++) begin
      src_q[i].push_back({1'b0, 8'(8'h10 * (i + 1))});
      src_q[i].push_back({1'b1, 8'(8'h10 * (i + 1) + 1)});
    end
    cyc0 = cyc;
    clear_log();
    drain("rr", 60);
    ed = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31, 32'h40, 32'h41};
    eo = '{0, 0, 1, 1, 2, 2, 3, 3};
    check_log("rr", ed, eo);
    // Request seen at cyc0+1, first write at cyc0+2, one idle cycle between bursts.
    exp_off = '{0, 1, 3, 4, 6, 7, 9, 10};
    if (wr_cyc.size() == 8) begin
      check("rr_first_write_cyc", wr_cyc[0], cyc0 + 2);
      for (int k = 1; k < 8; k++)
        check($sformatf("rr_write_gap%0d", k), wr_cyc[k] - wr_cyc[0], exp_off[k]);
    end

    // ---------------- tx_full stall mid-burst ----------------
    clear_log();
    src_q[2].push_back({1'b0, 8'h41});
    src_q[2].push_back({1'b0, 8'h42});
    src_q[2].push_back({1'b1, 8'h43});
    wait_writes("stall", 1, 10);
    full_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_ready%0d", k), req_ready[2], 0);
      check($sformatf("stall_write%0d", k), tx_write, 0);
      check($sformatf("stall_grant%0d", k), grant, 4'b0100);
    end
    drain("stall", 30);
    ed = '{32'h41, 32'h42, 32'h43};
    eo = '{2, 2, 2};
    check_log("stall", ed, eo);

    // ---------------- MAX_BURST forced release ----------------
    clear_log();
    abort_cnt = 0;
    for (int i = 0; i < 20; i++) src_q[1].push_back({(i == 19), 8'(8'h80 + i)});
    wait_writes("burst", 1, 10);
    src_q[3].push_back({1'b1, 8'hC0});
    drain("burst", 100);
    ed.delete();
    eo.delete();
    for (int i = 0; i < 16; i++) begin ed.push_back(8'h80 + i); eo.push_back(1); end
    ed.push_back(8'hC0); eo.push_back(3);
    for (int i = 16; i < 20; i++) begin ed.push_back(8'h80 + i); eo.push_back(1); end
    check_log("burst", ed, eo);
    check("burst_abort_count", abort_cnt, 1);
    if (wr_cyc.size() == 21) begin
      check("burst_abort_cyc", abort_cyc, wr_cyc[15] + 1);
      check("burst_next_grant_cyc", wr_cyc[16], wr_cyc[15] + 2);
    end

    // ---------------- owner holds with valid low ----------------
    clear_log();
    src_q[0].push_back({1'b0, 8'h50});
    src_q[0].push_back({1'b1, 8'h51});
    src_q[1].push_back({1'b1, 8'h66});
    wait_writes("hold", 1, 10);
    hold[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hold_grant%0d", k), grant, 4'b0001);
      check($sformatf("hold_write%0d", k), tx_write, 0);
    end
    hold[0] = 1'b0;
    drain("hold", 30);
    ed = '{32'h50, 32'h51, 32'h66};
    eo = '{0, 0, 1};
    check_log("hold", ed, eo);

    // ---------------- reset mid-burst ----------------
    clear_log();
    for (int i = 0; i < 5; i++) src_q[0].push_back({(i == 4), 8'(8'h70 + i)});
    wait_writes("mrst", 2, 10);
    rst_cmd = 1'b1;
    step();
    check("mrst_gate_write", tx_write, 0);
    check("mrst_gate_ready", req_ready, 0);
    step();
    check("mrst_grant", grant, 0);
    check("mrst_busy", busy, 0);
    check("mrst_writes", wr_data.size(), 2);
    rst_cmd = 1'b0;
    clear_log();
    src_q[2].push_back({1'b1, 8'hA0});
    drain("mrst", 40);
    ed = '{32'h72, 32'h73, 32'h74, 32'hA0};
    eo = '{0, 0, 0, 2};
    check_log("mrst", ed, eo);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
